// File: rtl/ecc_bus_arbiter.sv
// Round-robin arbiter that shares one ECC-protected bus channel among NUM_REQ requesters.
// One word is in flight at a time. Uncorrectable results are retried, and CE/UE counters saturate.
module ecc_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 8,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       bus_valid_in,
  output logic [31:0]                bus_data_in,
  input  logic                       bus_valid_out,
  input  logic [31:0]                bus_data_out,
  input  logic                       bus_err_det,
  input  logic                       bus_err_corr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_data,
  output logic [1:0]                 rsp_status,
  input  logic                       clear_counts,
  output logic [CNT_W-1:0]           ce_count,
  output logic [CNT_W-1:0]           ue_count,
  output logic [1:0]                 state_dbg
);

  // Handshakes: a requester word transfers on the cycle req_valid[i] and req_ready[i] are both high.
  // A response transfers on the cycle rsp_valid and rsp_ready are both high.
  // rsp_* stays stable while rsp_valid is high and rsp_ready is low.
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_CORR    = 2'b01;
  localparam logic [1:0] ST_FAILED  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant;
  logic [2:0]        retry_cnt;
  logic [TMR_W-1:0]  timer;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic              ce_inc;
  logic              ue_inc;
  logic              retry_now;

  // Scanning from the farthest candidate to the nearest lets the nearest one after last_grant win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign req_ready = (state == IDLE && win_found) ? (NUM_REQ'(1) << win_idx) : '0;
  assign state_dbg = state;

  assign retry_now = bus_err_det && !bus_err_corr && (retry_cnt < RETRY_MAX);
  assign ce_inc    = (state == WAIT) && bus_valid_out && bus_err_det && bus_err_corr;
  assign ue_inc    = (state == WAIT) &&
                     (bus_valid_out ? (bus_err_det && !bus_err_corr && retry_cnt >= RETRY_MAX)
                                    : (timer == TMR_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      grant        <= '0;
      retry_cnt    <= '0;
      timer        <= '0;
      bus_valid_in <= 1'b0;
      bus_data_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_status   <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant        <= win_idx;
            bus_data_in  <= req_data[32*int'(win_idx) +: 32];
            bus_valid_in <= 1'b1;
            retry_cnt    <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          bus_valid_in <= 1'b0;
          timer        <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (bus_valid_out) begin
            if (retry_now) begin
              // bus_data_in still holds the captured word, so a retry simply re-pulses valid.
              retry_cnt    <= retry_cnt + 3'd1;
              bus_valid_in <= 1'b1;
              state        <= ISSUE;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_id     <= grant;
              rsp_data   <= bus_data_out;
              rsp_status <= !bus_err_det ? ST_OK : (bus_err_corr ? ST_CORR : ST_FAILED);
              state      <= RESP;
            end
          end else if (timer == TMR_LAST) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant;
            rsp_data   <= '0;
            rsp_status <= ST_TIMEOUT;
            state      <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (clear_counts) begin
      ce_count <= '0;
      ue_count <= '0;
    end else begin
      if (ce_inc && ce_count != '1) ce_count <= ce_count + 1'b1;
      if (ue_inc && ue_count != '1) ue_count <= ue_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_bus_arbiter.sv
// Randomized bench for ecc_bus_arbiter. A transfer-level model predicts the grant order,
// the bus issue count, the response fields and the saturating counters.
module tb_ecc_bus_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int MAX_RETRY   = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  bus_valid_in;
  logic [31:0]           bus_data_in;
  logic                  bus_valid_out;
  logic [31:0]           bus_data_out;
  logic                  bus_err_det;
  logic                  bus_err_corr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [31:0]           rsp_data;
  logic [1:0]            rsp_status;
  logic                  clear_counts;
  logic [CNT_W-1:0]      ce_count;
  logic [CNT_W-1:0]      ue_count;
  logic [1:0]            state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int model_last = NUM_REQ - 1;
  int ce_m = 0;
  int ue_m = 0;

  ecc_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .bus_valid_in(bus_valid_in), .bus_data_in(bus_data_in),
    .bus_valid_out(bus_valid_out), .bus_data_out(bus_data_out),
    .bus_err_det(bus_err_det), .bus_err_corr(bus_err_corr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .clear_counts(clear_counts), .ce_count(ce_count), .ue_count(ue_count),
    .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The nearest requesting index after the previous grant wins, wrapping around.
  function automatic int pick(input logic [NUM_REQ-1:0] v);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(model_last + k) % NUM_REQ]) return (model_last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int sat(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_bus_valid"}, bus_valid_in, 0);
    check_eq({tag, "_bus_data"}, bus_data_in, 0);
    check_eq({tag, "_rsp_data"}, {rsp_id, rsp_data, rsp_status}, 0);
    check_eq({tag, "_ready"}, req_ready, 0);
    check_eq({tag, "_counts"}, {ce_count, ue_count}, 0);
    check_eq({tag, "_state"}, state_dbg, 0);
  endtask

  // Entered and left at a negedge with the DUT idle.
  // fin_kind selects the final bus outcome: 0 clean, 1 corrected, 2 no response.
  // n_ue is the number of uncorrectable results that come first.
  task automatic do_xfer(input logic [NUM_REQ-1:0] vld, input int n_ue, input int fin_kind,
                         input int delay, input bit clr);
    int g, n_issue, st, h;
    bit failed;
    logic [31:0] word, rdata, exp_d;
    req_valid = vld;
    for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = $urandom;
    #1;
    g = pick(vld);
    check_eq("grant", req_ready, 64'(1) << g);
    word    = req_data[32*g +: 32];
    failed  = (n_ue > MAX_RETRY);
    n_issue = failed ? MAX_RETRY + 1 : n_ue + 1;
    st      = 0;
    rdata   = '0;
    @(negedge clk);
    for (int i = 0; i < n_issue; i++) begin
      bit is_last;
      int kind, dly;
      is_last = (i == n_issue - 1);
      kind    = (!is_last || failed) ? 3 : fin_kind;
      dly     = is_last ? delay : $urandom_range(0, 2);
      check_eq("issue_valid", bus_valid_in, 1);
      check_eq("issue_data", bus_data_in, word);
      check_eq("ready_busy", req_ready, 0);
      @(negedge clk);
      check_eq("issue_pulse", bus_valid_in, 0);
      if (kind == 2) begin
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        check_eq("no_early_rsp", rsp_valid, 0);
        @(negedge clk);
        rdata = '0;
        st    = 3;
        ue_m  = sat(ue_m);
      end else begin
        repeat (dly) @(negedge clk);
        rdata         = $urandom;
        bus_valid_out = 1'b1;
        bus_data_out  = rdata;
        bus_err_det   = (kind != 0);
        bus_err_corr  = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind == 1);
        if (is_last) clear_counts = clr;
        @(negedge clk);
        bus_valid_out = 1'b0;
        bus_err_det   = 1'b0;
        bus_err_corr  = 1'b0;
        clear_counts  = 1'b0;
        if (is_last) begin
          if (kind == 0) st = 0;
          else if (kind == 1) begin st = 1; ce_m = sat(ce_m); end
          else begin st = 2; ue_m = sat(ue_m); end
          if (clr) begin ce_m = 0; ue_m = 0; end
        end
      end
    end
    exp_q.push_back(rdata);
    exp_d = exp_q.pop_front();
    h = $urandom_range(0, 3);
    // A stray bus response outside WAIT must leave the counters alone.
    if ($urandom_range(0, 1) == 1) begin
      bus_valid_out = 1'b1;
      bus_err_det   = 1'b1;
      bus_err_corr  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < h; i++) begin
      check_eq("rsp_hold_valid", rsp_valid, 1);
      check_eq("rsp_hold_fields", {rsp_id, rsp_data, rsp_status}, {2'(g), exp_d, 2'(st)});
      check_eq("no_reissue", bus_valid_in, 0);
      @(negedge clk);
      bus_valid_out = 1'b0;
    end
    rsp_ready = 1'b1;
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_id", rsp_id, g);
    check_eq("rsp_data", rsp_data, exp_d);
    check_eq("rsp_status", rsp_status, st);
    @(negedge clk);
    rsp_ready     = 1'b0;
    bus_valid_out = 1'b0;
    bus_err_det   = 1'b0;
    bus_err_corr  = 1'b0;
    check_eq("rsp_done", rsp_valid, 0);
    model_last = g;
    check_eq("ce_count", ce_count, ce_m);
    check_eq("ue_count", ue_count, ue_m);
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; rsp_ready = 1'b0; clear_counts = 1'b0;
    bus_valid_out = 1'b0; bus_data_out = '0; bus_err_det = 1'b0; bus_err_corr = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    do_xfer(4'b0001, 0, 0, 0, 1'b0);
    repeat (4) do_xfer(4'b0101, 0, 0, 0, 1'b0);
    do_xfer(4'b1000, 0, 1, 0, 1'b0);
    do_xfer(4'($urandom_range(1, 15)), 3, 0, 0, 1'b0);
    do_xfer(4'($urandom_range(1, 15)), 2, 0, 0, 1'b0);
    do_xfer(4'($urandom_range(1, 15)), 0, 2, 0, 1'b0);
    do_xfer(4'($urandom_range(1, 15)), 0, 0, TIMEOUT_CYC - 1, 1'b0);
    repeat (CNT_MAX + 2) do_xfer(4'($urandom_range(1, 15)), 0, 1, 0, 1'b0);
    do_xfer(4'($urandom_range(1, 15)), 0, 1, 0, 1'b1);

    for (int n = 0; n < 60; n++)
      do_xfer(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom_range(0, TIMEOUT_CYC - 1), ($urandom_range(0, 7) == 0));

    // Reset while waiting on the bus: the word is dropped and arbitration restarts at requester 0.
    req_valid = 4'b1111;
    #1;
    g = pick(4'b1111);
    check_eq("pre_reset_grant", req_ready, 64'(1) << g);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_quiet("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_last = NUM_REQ - 1;
    ce_m = 0;
    ue_m = 0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_eq("dropped_rsp", rsp_valid, 0);
    end
    do_xfer(4'b1111, 0, 0, 0, 1'b0);
    do_xfer(4'b1111, 1, 1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ecc_bus_arbiter.md
Name: ecc_bus_arbiter

Overview:
- Shares one ECC-protected 32-bit bus channel (encoder, latch, decoder; 1-cycle latency) among NUM_REQ requesters.
- Arbitrates round-robin, issues one word at a time and waits for the decoded result.
- On an uncorrectable error, retries the same word up to MAX_RETRY times, then returns a per-transfer status.
- Keeps saturating corrected-error (CE) and uncorrectable-error (UE) counters for status registers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_RETRY, 2, re-issues allowed after an uncorrectable result (0..7).
- TIMEOUT_CYC, 8, WAIT cycles without a bus response before giving up (>=2).
- CNT_W, 16, width of the CE/UE counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*32  requester i's word at bits [32*i+31:32*i]
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- bus_valid_in  out  1  word valid to the ECC bus
- bus_data_in  out  32  word to the ECC bus
- bus_valid_out  in  1  decoded word valid from the bus
- bus_data_out  in  32  decoded/corrected word
- bus_err_det  in  1  bus error-detected flag
- bus_err_corr  in  1  bus single-bit-corrected flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response
- rsp_data  out  32  returned word
- rsp_status  out  2  00 OK, 01 CORRECTED, 10 FAILED, 11 TIMEOUT
- clear_counts  in  1  synchronous clear of both counters
- ce_count  out  CNT_W  saturating corrected-error count
- ue_count  out  CNT_W  saturating failed-transfer count

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; retry and timer counters 0; last_grant = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, any req_valid set:
  - Winner g = first set bit searching from last_grant+1 with wrap-around.
  - req_ready[g]=1 for exactly that cycle (combinational from req_valid and state); word and g captured.
  - retry_cnt cleared; next state ISSUE.
  - req_ready is never asserted outside IDLE.
- ISSUE: bus_valid_in=1 for exactly one cycle with bus_data_in = captured word; timer cleared; next state WAIT.
- WAIT, bus_valid_out=1 (nominally the cycle after ISSUE):
  - err_det=0: status OK, rsp_data = bus_data_out, go RESP.
  - err_det=1, err_corr=1: status CORRECTED, rsp_data = bus_data_out, ce_count+1, go RESP.
  - err_det=1, err_corr=0, retry_cnt<MAX_RETRY: retry_cnt+1, go ISSUE; same captured word re-sent.
  - err_det=1, err_corr=0, retry_cnt==MAX_RETRY: status FAILED, rsp_data = bus_data_out (uncorrected), ue_count+1, go RESP.
  - err_corr=1 with err_det=0 is treated as OK.
- WAIT, bus_valid_out=0: timer+1. When timer reaches TIMEOUT_CYC-1:
  - status TIMEOUT, rsp_data=0, ue_count+1, go RESP.
  - A response arriving in that same cycle takes priority over the timeout.
- bus_valid_out outside WAIT: ignored; no counter change.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_status held stable until rsp_ready.
  - On rsp_valid && rsp_ready: last_grant = g, go IDLE.
  - Next arbitration happens in IDLE the following cycle.
- Throughput with a clean bus and rsp_ready held high: one transfer per 4 cycles (IDLE, ISSUE, WAIT, RESP).
- Counters:
  - Saturate at all-ones.
  - clear_counts wins over a same-cycle increment (result 0).
- Reset mid-operation: any state returns to IDLE immediately; the in-flight word is dropped with no response. Requesters re-present it.

Test Plan:
- Clean path: req_valid=0001, req_data[0]=0xDEADBEEF, bus returns 0xDEADBEEF with no error -> req_ready=0001 one cycle; bus_valid_in one cycle later; rsp_valid with id 0, data 0xDEADBEEF, status 00; ce/ue unchanged.
- Fairness: req_valid=0101 held for 4 transfers -> grants in order 0, 2, 0, 2; rsp_id matches each grant; no requester starved.
- Correction: bus returns err_det=1, err_corr=1, data 0x12345678 -> status 01, ce_count 0->1, single bus issue.
- Retry exhaust, MAX_RETRY=2: bus_err_det=1, err_corr=0 on every response -> exactly 3 bus_valid_in pulses, all with the same data, then status 10 and ue_count+1; when the 3rd response is clean instead -> status 00.
- Timeout, TIMEOUT_CYC=8: bus_valid_out never asserted -> rsp_valid with status 11 and data 0 exactly 8 cycles after entering WAIT; ue_count+1.
- Counters and reset: preload ce_count to all-ones, then trigger a correction -> stays all-ones; clear_counts in the same cycle as an increment -> 0; rst_n low during WAIT -> all outputs 0 next edge, no response, FSM idle and re-arbitrates from requester 0.
